// File: rtl/mips32_pkg.sv
// Shared constants, opcodes and control types for the single-cycle MIPS32-subset core.
// The MIPS32_SLT_EN macro enables SLT/SLTI decode in mips32_decoder.
package mips32_pkg;

  localparam int DATA_W  = 32;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL
  } alu_op_t;

  typedef struct packed {
    logic    reg_wr;
    logic    mem_wr;
    logic    mem_rd;
    logic    alu_src_imm;
    alu_op_t alu_op;
    logic    dst_rt;
    logic    wb_mem;
    logic    br_eqz;
    logic    br_neqz;
    logic    halt;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips32_if.sv
// Status bus of the core: current PC and halt flag.
interface mips32_if #(parameter int PC_W = 10);
  logic [PC_W-1:0] pc;
  logic            halted;

  modport master (output pc, output halted);
  modport slave  (input pc, input halted);
endinterface

// File: rtl/mips32_decoder.sv
// Opcode to control-word decode. SLT/SLTI decode only when MIPS32_SLT_EN is defined;
// otherwise they fall into the NOP default.
module mips32_decoder
  import mips32_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl
);

  // control word: every field defaults to a NOP, each opcode sets only what it needs
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (op)
      OP_ADD:  begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_SUB:  begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_AND:  begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_OR:   begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_MUL:  begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_MUL; end
`ifdef MIPS32_SLT_EN
      OP_SLT:  begin ctrl.reg_wr = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_SLTI: begin
        ctrl.reg_wr = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.dst_rt = 1'b1; ctrl.alu_op = ALU_SLT;
      end
`endif
      OP_ADDI: begin
        ctrl.reg_wr = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.dst_rt = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_SUBI: begin
        ctrl.reg_wr = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.dst_rt = 1'b1; ctrl.alu_op = ALU_SUB;
      end
      OP_LW: begin
        ctrl.reg_wr = 1'b1; ctrl.mem_rd = 1'b1; ctrl.wb_mem = 1'b1;
        ctrl.alu_src_imm = 1'b1; ctrl.dst_rt = 1'b1;
      end
      OP_SW:    begin ctrl.mem_wr = 1'b1; ctrl.alu_src_imm = 1'b1; end
      OP_BNEQZ: ctrl.br_neqz = 1'b1;
      OP_BEQZ:  ctrl.br_eqz  = 1'b1;
      OP_HLT:   ctrl.halt    = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/mips32_mem.sv
// Word-addressed memory: combinational read, write on rising edge, never reset.
module mips32_mem
  import mips32_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port; contents survive reset so the bench can preload them
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = re ? mem[addr] : '0;

endmodule

// File: rtl/mips32_regfile.sv
// 32x32 register file, two combinational read ports, R0 hard-wired to zero.
module mips32_regfile
  import mips32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [32];

  // async clear of all registers; writes to R0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips32_sc_core.sv
// Single-cycle MIPS32-subset core: one instruction fetched, executed and committed per clk.
// Define MIPS32_SLT_EN to implement SLT/SLTI; otherwise they execute as NOPs.
module mips32_sc_core
  import mips32_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic     clk,
  input  logic     clr_PC,
  mips32_if.master status
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  logic [PC_W-1:0]   pc_q, pc_next;
  logic              halted_q;
  logic [DATA_W-1:0] instr, rs_val, rt_val, imm_ext, alu_b, alu_y, dmem_rdata, wb_data;
  logic [4:0]        rs, rt, rd, wr_dst;
  logic              taken, run;
  ctrl_t             ctrl;

  mips32_mem #(.DEPTH(IMEM_DEPTH)) u_imem (
    .clk(clk), .we(1'b0), .re(1'b1), .addr(pc_q), .wdata('0), .rdata(instr)
  );

  mips32_decoder u_dec (.op(instr[OP_MSB:OP_LSB]), .ctrl(ctrl));

  assign rs      = instr[RS_MSB:RS_LSB];
  assign rt      = instr[RT_MSB:RT_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign imm_ext = sext16(instr[IMM_MSB:0]);
  assign wr_dst  = ctrl.dst_rt ? rt : rd;
  assign run     = ~halted_q;

  mips32_regfile u_rf (
    .clk(clk), .rst_n(clr_PC), .we(ctrl.reg_wr & run), .wa(wr_dst), .wd(wb_data),
    .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val)
  );

  assign alu_b = ctrl.alu_src_imm ? imm_ext : rt_val;

  // ALU: 32-bit wrapping arithmetic, signed compare for SLT
  always_comb begin
    alu_y = '0;
    case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(alu_b))};
      ALU_MUL: alu_y = rs_val * alu_b;
      default: alu_y = '0;
    endcase
  end

  // reset gates the data-memory write since memories themselves are not reset
  mips32_mem #(.DEPTH(DMEM_DEPTH)) u_dmem (
    .clk(clk), .we(ctrl.mem_wr & run & clr_PC), .re(ctrl.mem_rd),
    .addr(alu_y[DA_W-1:0]), .wdata(rt_val), .rdata(dmem_rdata)
  );

  assign wb_data = ctrl.wb_mem ? dmem_rdata : alu_y;
  assign taken   = (ctrl.br_eqz && (rs_val == '0)) || (ctrl.br_neqz && (rs_val != '0));

  // next PC: frozen on halt, relative branch wraps within the instruction memory
  always_comb begin
    pc_next = pc_q + PC_W'(1);
    if (halted_q || ctrl.halt) pc_next = pc_q;
    else if (taken)            pc_next = pc_q + PC_W'(1) + imm_ext[PC_W-1:0];
  end

  // PC and halt flag
  always_ff @(posedge clk or negedge clr_PC) begin
    if (!clr_PC) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_next;
      halted_q <= halted_q | ctrl.halt;
    end
  end

  assign status.pc     = pc_q;
  assign status.halted = halted_q;

endmodule

// File: tb/tb_mips32_sc_core.sv
// Directed bench for mips32_sc_core; expectations are hand-computed per program.
module tb_mips32_sc_core;
  import mips32_pkg::*;

  logic clk    = 1'b0;
  logic clr_PC = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] prog[$];
  logic [31:0] slt_exp;

  mips32_if status_if ();

  mips32_sc_core dut (.clk(clk), .clr_PC(clr_PC), .status(status_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // hold reset, load prog (rest of imem = HLT), release mid-cycle
  task automatic start();
    clr_PC = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.u_imem.mem[i] = 32'hfc000000;
    for (int i = 0; i < prog.size(); i++) dut.u_imem.mem[i] = prog[i];
    @(posedge clk);
    @(negedge clk);
    clr_PC = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.u_rf.regs[i];
  endfunction

  initial begin
    // reset held over an edge
    @(posedge clk);
    #1;
    chk("rst_pc", 32'(status_if.pc), 32'd0);
    chk("rst_halted", 32'(status_if.halted), 32'd0);
    chk("rst_r5", rf(5), 32'd0);
    chk("rst_r31", rf(31), 32'd0);

    // factorial of 5
    for (int i = 0; i < 1024; i++) dut.u_dmem.mem[i] = 32'd0;
    dut.u_dmem.mem[200] = 32'd5;
    prog = {32'h200100c8, 32'h28020001, 32'h14411000, 32'h2c210001,
            32'h3420fffd, 32'h240200c6, 32'hfc000000};
    start();
    chk("release_pc", 32'(status_if.pc), 32'd0);
    run(25);
    chk("fact_dmem198", dut.u_dmem.mem[198], 32'd120);
    chk("fact_r2", rf(2), 32'd120);
    chk("fact_r1", rf(1), 32'd0);
    chk("fact_halted", 32'(status_if.halted), 32'd1);
    chk("fact_pc", 32'(status_if.pc), 32'd6);
    run(5);
    chk("halt_pc", 32'(status_if.pc), 32'd6);
    chk("halt_r2", rf(2), 32'd120);
    chk("halt_dmem", dut.u_dmem.mem[198], 32'd120);

    // asynchronous reset in the middle of the factorial loop
    start();
    run(8);
    chk("mid_pc_before", 32'(status_if.pc), 32'd2);
    chk("mid_r2_before", rf(2), 32'd20);
    #2 clr_PC = 1'b0;
    #1;
    chk("mid_pc_after", 32'(status_if.pc), 32'd0);
    chk("mid_r2_after", rf(2), 32'd0);
    chk("mid_halted", 32'(status_if.halted), 32'd0);

    // ALU operations
    prog = {i_ins(OP_ADDI, 0, 1, 16'd7), i_ins(OP_ADDI, 0, 2, 16'hfffd),
            r_ins(OP_ADD, 1, 2, 3), r_ins(OP_SUB, 1, 2, 4), r_ins(OP_AND, 1, 2, 5),
            r_ins(OP_OR, 1, 2, 6), r_ins(OP_MUL, 1, 2, 7)};
    start();
    run(10);
    chk("alu_add", rf(3), 32'd4);
    chk("alu_sub", rf(4), 32'd10);
    chk("alu_and", rf(5), 32'd5);
    chk("alu_or", rf(6), 32'hffffffff);
    chk("alu_mul", rf(7), 32'hffffffeb);
    chk("alu_pc", 32'(status_if.pc), 32'd7);

    // R0 is never written
    prog = {i_ins(OP_ADDI, 0, 1, 16'd9), i_ins(OP_ADDI, 0, 0, 16'd5), r_ins(OP_ADD, 0, 0, 1)};
    start();
    run(6);
    chk("r0_r1", rf(1), 32'd0);
    chk("r0_reg", rf(0), 32'd0);

    // branches: BEQZ taken skips two, BNEQZ on zero falls through
    prog = {i_ins(OP_BEQZ, 0, 0, 16'd2), i_ins(OP_ADDI, 0, 1, 16'd1),
            i_ins(OP_ADDI, 0, 2, 16'd2), i_ins(OP_BNEQZ, 0, 0, 16'd2),
            i_ins(OP_ADDI, 0, 3, 16'd3)};
    start();
    run(10);
    chk("br_r1", rf(1), 32'd0);
    chk("br_r2", rf(2), 32'd0);
    chk("br_r3", rf(3), 32'd3);
    chk("br_pc", 32'(status_if.pc), 32'd5);

    // data address wraps modulo DMEM_DEPTH: 1000+30 -> word 6
    dut.u_dmem.mem[6] = 32'd0;
    prog = {i_ins(OP_ADDI, 0, 1, 16'd1000), i_ins(OP_SW, 1, 1, 16'd30),
            i_ins(OP_LW, 0, 2, 16'd6)};
    start();
    run(6);
    chk("wrap_dmem6", dut.u_dmem.mem[6], 32'd1000);
    chk("wrap_lw_r2", rf(2), 32'd1000);

    // PC wraps backwards: 0+1-2 -> 1023 (HLT)
    prog = {i_ins(OP_BEQZ, 0, 0, 16'hfffe)};
    start();
    run(4);
    chk("pcwrap_pc", 32'(status_if.pc), 32'd1023);
    chk("pcwrap_halted", 32'(status_if.halted), 32'd1);

    // SLT/SLTI, NOPs when the option is not built
`ifdef MIPS32_SLT_EN
    slt_exp = 32'd1;
`else
    slt_exp = 32'd0;
`endif
    prog = {i_ins(OP_ADDI, 0, 2, 16'hfffd), i_ins(OP_SLTI, 2, 1, 16'd0),
            r_ins(OP_SLT, 2, 0, 4), r_ins(OP_SLT, 0, 2, 5)};
    start();
    run(8);
    chk("slti_r1", rf(1), slt_exp);
    chk("slt_r4", rf(4), slt_exp);
    chk("slt_r5", rf(5), 32'd0);
    chk("slt_pc", 32'(status_if.pc), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
